// File: rtl/uart_rx_oversampled_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampled_pkg
// Shared UART definitions: FSM state encodings, default framing parameters,
// parameter legality checks and the even-parity helper. Intended to be reused
// by the future uart_tx.
// Optional feature macro used by the receiver: UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
package uart_rx_oversampled_pkg;

  localparam int unsigned DEFAULT_OSR       = 8;
  localparam int unsigned DEFAULT_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // The sampling point sits at OSR/2, so the rate must be even and leave room
  // for a mid-bit sample distinct from the bit edges.
  function automatic bit osr_is_legal(input int unsigned osr);
    return (osr >= 32'd4) && ((osr % 32'd2) == 32'd0);
  endfunction

  function automatic bit data_bits_legal(input int unsigned bits);
    return (bits >= 32'd5) && (bits <= 32'd9);
  endfunction

  // Even parity: XOR over data word plus parity bit must be zero. Words are
  // zero-extended to 9 bits, which does not change the XOR reduction.
  function automatic logic parity_mismatch(input logic [8:0] word, input logic par_bit);
    return ^{word, par_bit};
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// 2-FF synchroniser for an asynchronous single-bit input plus a registered
// one-cycle rising-edge pulse.
// Ports:
//   clk_in    - system clock
//   nrst_in   - synchronous active-low reset (all flops to 0)
//   async_in  - asynchronous input
//   level_out - synchronised level
//   rise_out  - one clk_in cycle pulse per rising edge of the synchronised level
// -----------------------------------------------------------------------------
module sync_edge_detect (
  input  logic clk_in,
  input  logic nrst_in,
  input  logic async_in,
  output logic level_out,
  output logic rise_out
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic rise_q,  rise_d;

  // Next-state: shift the synchroniser chain and detect a 0->1 transition.
  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
  end

  // Synchroniser and edge-detect flops with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (!nrst_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
    end
  end

  assign level_out = sync2_q;
  assign rise_out  = rise_q;

endmodule

// File: rtl/uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampled
// 8N1-style UART receiver driven by the rising edges of an oversampling clock
// (treated as data and synchronised into clk_in). Each received word is shown
// on data_out with a one-cycle data_valid_out strobe; a low stop bit gives a
// one-cycle frame_err_out instead.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit after
// the data bits and the parity_err_out pulse output.
// Ports:
//   clk_in         - system clock
//   nrst_in        - synchronous active-low reset
//   os_clk_in      - oversampling clock from the baud generator
//   rx_in          - asynchronous serial line, idle high
//   data_out       - last good received word
//   data_valid_out - one-cycle pulse, data_out is new
//   frame_err_out  - one-cycle pulse, stop bit sampled low
//   parity_err_out - (UART_RX_PARITY_EN only) one-cycle pulse, parity mismatch
//   busy_out       - high while the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_oversampled
  import uart_rx_oversampled_pkg::*;
#(
  parameter int unsigned OVERSAMPLING_RATE = DEFAULT_OSR,
  parameter int unsigned DATA_BITS         = DEFAULT_DATA_BITS
) (
  input  logic                 clk_in,
  input  logic                 nrst_in,
  input  logic                 os_clk_in,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid_out,
  output logic                 frame_err_out,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err_out,
`endif
  output logic                 busy_out
);

  localparam int unsigned OS_W  = $clog2(OVERSAMPLING_RATE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLING_RATE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLING_RATE - 1);
  localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  if (!osr_is_legal(OVERSAMPLING_RATE)) begin : g_bad_osr
    $error("OVERSAMPLING_RATE must be even and >= 4");
  end
  if (!data_bits_legal(DATA_BITS)) begin : g_bad_data_bits
    $error("DATA_BITS must be in 5..9");
  end

`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = ST_PARITY;
`else
  localparam rx_state_e AFTER_DATA = ST_STOP;
`endif

  logic tick_s;
  logic rx_s;
  logic os_level_unused_s;
  logic rx_rise_unused_s;

  sync_edge_detect u_os_sync (
    .clk_in    (clk_in),
    .nrst_in   (nrst_in),
    .async_in  (os_clk_in),
    .level_out (os_level_unused_s),
    .rise_out  (tick_s)
  );

  sync_edge_detect u_rx_sync (
    .clk_in    (clk_in),
    .nrst_in   (nrst_in),
    .async_in  (rx_in),
    .level_out (rx_s),
    .rise_out  (rx_rise_unused_s)
  );

  rx_state_e            state_q,   state_d;
  logic [OS_W-1:0]      os_cnt_q,  os_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 valid_q,   valid_d;
  logic                 ferr_q,    ferr_d;
  logic                 busy_q,    busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q,    perr_d;
`endif

  // Next-state logic: every state/counter change is gated by tick_s, while the
  // pulse outputs default to 0 so they last exactly one clk_in cycle.
  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    if (tick_s) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d  = ST_START;
            os_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (os_cnt_q == OS_MID) begin
            os_cnt_d  = '0;
            bit_cnt_d = '0;
            // A line that is high again at mid start bit was a glitch.
            if (!rx_s) begin
              state_d = ST_DATA;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end
        ST_DATA: begin
          if (os_cnt_q == OS_LAST) begin
            // Right shift: the first (LSB) bit ends up in bit 0.
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            os_cnt_d  = '0;
            bit_cnt_d = bit_cnt_q + BIT_ONE;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = AFTER_DATA;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (os_cnt_q == OS_LAST) begin
            par_bad_d = parity_mismatch(9'(shift_q), rx_s);
            os_cnt_d  = '0;
            state_d   = ST_STOP;
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (os_cnt_q == OS_LAST) begin
            // Leave at mid stop bit to gain half a bit of resync margin.
            state_d  = ST_IDLE;
            os_cnt_d = '0;
            if (!rx_s) begin
              ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              perr_d = 1'b1;
`endif
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          os_cnt_d  = '0;
          bit_cnt_d = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // FSM, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (!nrst_in) begin
      state_q   <= ST_IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_out       = data_q;
  assign data_valid_out = valid_q;
  assign frame_err_out  = ferr_q;
  assign busy_out       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_out = perr_q;
`endif

endmodule
